pon_burst_timing_ctrl: RTL



---
 rtl/pon_burst_timing_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pon_burst_timing_ctrl.sv
// Upstream PON burst envelope generator: shadows VIO config at period boundaries, outputs registered from next-state.
// Optional burst counter under `PON_BURST_STATS_EN`; otherwise burst_count is tied to zero.
module pon_burst_timing_ctrl (
  input  logic        hb0_gtwiz_userclk_tx_usrclk2_int,
  input  logic        hb0_burst_reset_n_int,
  input  logic [31:0] preamble_length_vio_int,
  input  logic [31:0] burst_length_vio_int,
  input  logic [31:0] burst_period_vio_int,
  input  logic        b2bcontrol,
  output logic        tx_burst_en,
  output logic        preamble_active,
  output logic        data_active,
  output logic        burst_start,
  output logic        cfg_error,
  output logic [15:0] burst_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_GUARD,
    ST_CONT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] p_s_q, p_s_d;
  logic [31:0] b_s_q, b_s_d;
  logic [31:0] t_s_q, t_s_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic        cfg_error_q, cfg_error_d;
  logic        preamble_active_q, preamble_active_d;
  logic        data_active_q, data_active_d;
  logic        tx_burst_en_q, tx_burst_en_d;
  logic        burst_start_q, burst_start_d;

  logic [32:0] cfg_sum;
  logic [32:0] win_end_s;
  logic        cfg_valid;
  logic        in_burst;
  logic        boundary;
  logic        period_start;

  // P+B is formed in 33 bits so large VIO values cannot wrap into a "valid" config.
  always_comb begin
    cfg_sum   = {1'b0, preamble_length_vio_int} + {1'b0, burst_length_vio_int};
    cfg_valid = (burst_period_vio_int != 32'd0) && (cfg_sum <= {1'b0, burst_period_vio_int});
    win_end_s = {1'b0, p_s_q} + {1'b0, b_s_q};
    in_burst  = (state_q == ST_PREAMBLE) || (state_q == ST_DATA) || (state_q == ST_GUARD);
    boundary  = (state_q == ST_IDLE) ||
                (in_burst && (period_cnt_q == t_s_q - 32'd1));
  end

  always_comb begin
    state_d      = state_q;
    p_s_d        = p_s_q;
    b_s_d        = b_s_q;
    t_s_d        = t_s_q;
    period_cnt_d = period_cnt_q;
    cfg_error_d  = 1'b0;
    period_start = 1'b0;

    if (state_q == ST_CONT) begin
      if (!b2bcontrol) begin
        state_d = ST_IDLE;
      end
    end else if (boundary) begin
      p_s_d        = preamble_length_vio_int;
      b_s_d        = burst_length_vio_int;
      t_s_d        = burst_period_vio_int;
      period_cnt_d = 32'd0;
      if (b2bcontrol) begin
        state_d = ST_CONT;
      end else if (!cfg_valid) begin
        state_d     = ST_IDLE;
        cfg_error_d = 1'b1;
      end else if (preamble_length_vio_int != 32'd0) begin
        state_d      = ST_PREAMBLE;
        period_start = 1'b1;
      end else if (burst_length_vio_int != 32'd0) begin
        state_d      = ST_DATA;
        period_start = 1'b1;
      end else begin
        state_d = ST_GUARD;
      end
    end else begin
      period_cnt_d = period_cnt_q + 32'd1;
      case (state_q)
        ST_PREAMBLE: begin
          if (period_cnt_q == p_s_q - 32'd1) begin
            state_d = (b_s_q != 32'd0) ? ST_DATA : ST_GUARD;
          end
        end
        ST_DATA: begin
          if ({1'b0, period_cnt_q} == win_end_s - 33'd1) begin
            state_d = ST_GUARD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode the next state so they line up with the state they describe.
  always_comb begin
    preamble_active_d = (state_d == ST_PREAMBLE);
    data_active_d     = (state_d == ST_DATA) || (state_d == ST_CONT);
    tx_burst_en_d     = preamble_active_d || data_active_d;
    burst_start_d     = period_start;
  end

  always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int) begin
    if (!hb0_burst_reset_n_int) begin
      state_q           <= ST_IDLE;
      p_s_q             <= 32'd0;
      b_s_q             <= 32'd0;
      t_s_q             <= 32'd0;
      period_cnt_q      <= 32'd0;
      cfg_error_q       <= 1'b0;
      preamble_active_q <= 1'b0;
      data_active_q     <= 1'b0;
      tx_burst_en_q     <= 1'b0;
      burst_start_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      p_s_q             <= p_s_d;
      b_s_q             <= b_s_d;
      t_s_q             <= t_s_d;
      period_cnt_q      <= period_cnt_d;
      cfg_error_q       <= cfg_error_d;
      preamble_active_q <= preamble_active_d;
      data_active_q     <= data_active_d;
      tx_burst_en_q     <= tx_burst_en_d;
      burst_start_q     <= burst_start_d;
    end
  end

  assign tx_burst_en     = tx_burst_en_q;
  assign preamble_active = preamble_active_q;
  assign data_active     = data_active_q;
  assign burst_start     = burst_start_q;
  assign cfg_error       = cfg_error_q;

`ifdef PON_BURST_STATS_EN
  logic [15:0] burst_count_q, burst_count_d;

  always_comb begin
    burst_count_d = burst_count_q + {15'd0, burst_start_d};
  end

  always_ff @(posedge hb0_gtwiz_userclk_tx_usrclk2_int) begin
    if (!hb0_burst_reset_n_int) begin
      burst_count_q <= 16'h0000;
    end else begin
      burst_count_q <= burst_count_d;
    end
  end

  assign burst_count = burst_count_q;
`else
  assign burst_count = 16'h0000;
`endif

endmodule
